// File: rtl/psum_drain_pkg.sv
// Shared types and constants for the psum drain engine.
package psum_drain_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StPop,
    StRd,
    StWr,
    StFin
  } state_e;

  localparam int unsigned COL     = 8;
  localparam int unsigned PSUM_BW = 16;
  localparam int unsigned ROW_W   = COL * PSUM_BW;

  // Active-low SRAM command pair {cen, wen}.
  typedef struct packed {
    logic cen;
    logic wen;
  } sram_cmd_t;

  localparam sram_cmd_t CMD_IDLE = '{cen: 1'b1, wen: 1'b1};
  localparam sram_cmd_t CMD_RD   = '{cen: 1'b0, wen: 1'b1};
  localparam sram_cmd_t CMD_WR   = '{cen: 1'b0, wen: 1'b0};

endpackage

// File: rtl/psum_lane_add.sv
// Lane-parallel wrapping adders; each lane is independent, no carry between lanes.
module psum_lane_add #(
  parameter int unsigned col     = 8,
  parameter int unsigned psum_bw = 16
) (
  input  logic [col*psum_bw-1:0] a_i,
  input  logic [col*psum_bw-1:0] b_i,
  output logic [col*psum_bw-1:0] sum_o
);

  for (genvar i = 0; i < col; i++) begin : g_lane
    assign sum_o[i*psum_bw +: psum_bw] = a_i[i*psum_bw +: psum_bw] + b_i[i*psum_bw +: psum_bw];
  end

endmodule

// File: rtl/psum_drain.sv
// Drains OFIFO rows into the psum SRAM at auto-incrementing addresses,
// optionally accumulating onto the stored row.
module psum_drain
  import psum_drain_pkg::*;
#(
  parameter int unsigned col     = 8,
  parameter int unsigned psum_bw = 16,
  parameter int unsigned addr_w  = 11,
  parameter int unsigned cnt_w   = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [addr_w-1:0]        base_addr_i,
  input  logic [cnt_w-1:0]         row_cnt_i,
  input  logic                     acc_en_i,
  input  logic                     ofifo_valid_i,
  input  logic [col*psum_bw-1:0]   ofifo_out_i,
  output logic                     ofifo_rd_o,
  output logic                     sram_cen_o,
  output logic                     sram_wen_o,
  output logic [addr_w-1:0]        sram_addr_o,
  output logic [col*psum_bw-1:0]   sram_d_o,
  input  logic [col*psum_bw-1:0]   sram_q_i,
  output logic                     busy_o,
  output logic                     done_o
);

  localparam int unsigned RowW = col * psum_bw;

  state_e            state_q, state_d;
  logic [addr_w-1:0] ptr_q, ptr_d;
  logic [addr_w-1:0] addr_q, addr_d;
  logic [cnt_w-1:0]  rem_q, rem_d;
  logic              acc_q, acc_d;
  logic [RowW-1:0]   row_q, row_d;
  logic [RowW-1:0]   dhold_q, dhold_d;
  logic [RowW-1:0]   sum;
  logic [RowW-1:0]   wr_data;
  sram_cmd_t         cmd;

  psum_lane_add #(
    .col    (col),
    .psum_bw(psum_bw)
  ) u_lane_add (
    .a_i  (row_q),
    .b_i  (sram_q_i),
    .sum_o(sum)
  );

  assign wr_data = acc_q ? sum : row_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    row_d   = row_q;
    dhold_d = dhold_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          ptr_d   = base_addr_i;
          rem_d   = row_cnt_i;
          acc_d   = acc_en_i;
          state_d = (row_cnt_i != '0) ? StWait : StFin;
        end
      end
      StWait: begin
        if (ofifo_valid_i) state_d = StPop;
      end
      StPop: begin
        row_d   = ofifo_out_i;
        // The address register only moves here, so it holds outside RD/WR.
        addr_d  = ptr_q;
        state_d = acc_q ? StRd : StWr;
      end
      StRd: begin
        state_d = StWr;
      end
      StWr: begin
        ptr_d   = ptr_q + addr_w'(1);
        rem_d   = rem_q - cnt_w'(1);
        dhold_d = wr_data;
        state_d = (rem_q == cnt_w'(1)) ? StFin : StWait;
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      addr_q  <= '0;
      rem_q   <= '0;
      acc_q   <= 1'b0;
      row_q   <= '0;
      dhold_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      acc_q   <= acc_d;
      row_q   <= row_d;
      dhold_q <= dhold_d;
    end
  end

  always_comb begin
    cmd = CMD_IDLE;
    if (state_q == StRd) cmd = CMD_RD;
    if (state_q == StWr) cmd = CMD_WR;
  end

  assign sram_cen_o  = cmd.cen;
  assign sram_wen_o  = cmd.wen;
  assign sram_addr_o = addr_q;
  // Write data is live only in WR; otherwise the last written row is held.
  assign sram_d_o    = (state_q == StWr) ? wr_data : dhold_q;
  assign ofifo_rd_o  = (state_q == StPop);
  assign busy_o      = (state_q != StIdle);
  assign done_o      = (state_q == StFin);

endmodule
